// File: rtl/scheduler_ctrl_pkg.sv
// Shared types and helpers for the Scheduler input front end: tick-sequence states,
// packet width arithmetic and {axon, delay} field slicing.
package scheduler_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_ACCEPT = 2'd0,
        ST_CLR    = 2'd1,
        ST_SET    = 2'd2
    } sched_state_e;

    localparam int PKT_MAX_W = 32;

    function automatic int field_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int pkt_w(input int num_axons, input int num_ticks);
        return field_w(num_axons) + field_w(num_ticks);
    endfunction

    // Delay occupies the LSBs of a packet, axon sits directly above it
    function automatic logic [PKT_MAX_W-1:0] pkt_delay(input logic [PKT_MAX_W-1:0] pkt,
                                                       input int delay_w);
        return pkt & ((32'd1 << delay_w) - 32'd1);
    endfunction

    function automatic logic [PKT_MAX_W-1:0] pkt_axon(input logic [PKT_MAX_W-1:0] pkt,
                                                      input int delay_w);
        return pkt >> delay_w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant among req, search starts at the port after the
// last one that transferred; the pointer moves only when advance is strobed.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int          PTR_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [N-1:0] ONE  = N'(1'b1);

    logic [PTR_W-1:0] ptr_r;
    logic [PTR_W-1:0] grant_idx_s;
    logic [PTR_W-1:0] next_ptr_s;
    logic [N-1:0]     upper_mask_s;
    logic [N-1:0]     hi_req_s;
    logic [N-1:0]     hi_grant_s;
    logic [N-1:0]     lo_grant_s;

    // Lowest requester at or above the pointer wins, otherwise wrap to the lowest overall
    always_comb begin
        upper_mask_s = ~((ONE << ptr_r) - ONE);
        hi_req_s     = req & upper_mask_s;
        hi_grant_s   = hi_req_s & (~hi_req_s + ONE);
        lo_grant_s   = req & (~req + ONE);
        grant        = (|hi_req_s) ? hi_grant_s : lo_grant_s;
    end

    // Encode the grant and compute the next search start (granted port + 1, wrapping)
    always_comb begin
        grant_idx_s = {PTR_W{1'b0}};
        for (int j = 0; j < N; j++) begin
            grant_idx_s = grant_idx_s | (grant[j] ? PTR_W'(j) : {PTR_W{1'b0}});
        end
        next_ptr_s = (grant_idx_s == PTR_W'(N - 1)) ? {PTR_W{1'b0}}
                                                    : grant_idx_s + PTR_W'(1'b1);
    end

    // Search-start pointer register
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_r <= {PTR_W{1'b0}};
        end else if (advance) begin
            ptr_r <= next_ptr_s;
        end
    end

endmodule

// File: rtl/scheduler_input_arbiter.sv
// Scheduler front end: merges requester packets into the single Scheduler write port,
// sequences each tick (block, clear row, advance read counter) and counts collisions.
module scheduler_input_arbiter
    import scheduler_ctrl_pkg::*;
#(
    parameter  int NUM_PORTS     = 2,
    parameter  int NUM_AXONS     = 256,
    parameter  int NUM_TICKS     = 16,
    parameter  int ERR_CNT_WIDTH = 8,
    localparam int PKT_W         = pkt_w(NUM_AXONS, NUM_TICKS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       tick,
    input  logic [NUM_PORTS-1:0]       req_valid,
    input  logic [NUM_PORTS*PKT_W-1:0] req_packet,
    output logic [NUM_PORTS-1:0]       req_ready,
    output logic                       sched_wen,
    output logic [PKT_W-1:0]           sched_packet,
    output logic                       sched_clr,
    output logic                       sched_set,
    input  logic                       sched_error,
    input  logic                       err_clr,
    output logic                       tick_done,
    output logic [ERR_CNT_WIDTH-1:0]   err_count,
    output logic                       tick_overrun
);

    sched_state_e               state_r;
    logic                       pending_r;
    logic                       overrun_r;
    logic [ERR_CNT_WIDTH-1:0]   err_count_r;
    logic                       wen_r;
    logic [PKT_W-1:0]           packet_r;
    logic                       clr_r;
    logic                       set_r;
    logic                       done_r;

    logic [NUM_PORTS-1:0]       grant_s;
    logic [NUM_PORTS-1:0]       ready_s;
    logic                       accept_s;
    logic                       transfer_s;
    logic                       overrun_event_s;
    logic [PKT_W-1:0]           sel_packet_s;

    rr_arbiter #(
        .N (NUM_PORTS)
    ) u_rr_arbiter (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .advance (transfer_s),
        .grant   (grant_s)
    );

    // Grant only in ACCEPT and out of reset; a tick this cycle takes priority over packets
    always_comb begin
        accept_s        = rst & (state_r == ST_ACCEPT) & ~tick;
        ready_s         = accept_s ? grant_s : {NUM_PORTS{1'b0}};
        transfer_s      = |(ready_s & req_valid);
        overrun_event_s = tick & pending_r;
        sel_packet_s    = {PKT_W{1'b0}};
        for (int j = 0; j < NUM_PORTS; j++) begin
            sel_packet_s = sel_packet_s |
                           (ready_s[j] ? req_packet[j*PKT_W +: PKT_W] : {PKT_W{1'b0}});
        end
    end

    // Tick sequencer; a tick arriving mid-sequence chains a second CLR/SET without an ACCEPT gap
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r   <= ST_ACCEPT;
            pending_r <= 1'b0;
            clr_r     <= 1'b0;
            set_r     <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            clr_r  <= 1'b0;
            set_r  <= 1'b0;
            done_r <= 1'b0;
            case (state_r)
                ST_ACCEPT: begin
                    if (tick) begin
                        state_r <= ST_CLR;
                        clr_r   <= 1'b1;
                    end
                end
                ST_CLR: begin
                    state_r <= ST_SET;
                    set_r   <= 1'b1;
                    done_r  <= 1'b1;
                    if (tick && !pending_r) begin
                        pending_r <= 1'b1;
                    end
                end
                ST_SET: begin
                    pending_r <= 1'b0;
                    if (pending_r || tick) begin
                        state_r <= ST_CLR;
                        clr_r   <= 1'b1;
                    end else begin
                        state_r <= ST_ACCEPT;
                    end
                end
                default: begin
                    state_r <= ST_ACCEPT;
                end
            endcase
        end
    end

    // Write path: accepted packet appears one cycle later; packet holds when idle
    always_ff @(posedge clk) begin
        if (!rst) begin
            wen_r    <= 1'b0;
            packet_r <= {PKT_W{1'b0}};
        end else begin
            wen_r <= transfer_s;
            if (transfer_s) begin
                packet_r <= sel_packet_s;
            end
        end
    end

    // Saturating collision counter and sticky overrun flag; err_clr wins over a new event
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_count_r <= {ERR_CNT_WIDTH{1'b0}};
            overrun_r   <= 1'b0;
        end else begin
            if (err_clr) begin
                err_count_r <= {ERR_CNT_WIDTH{1'b0}};
            end else if (wen_r && sched_error && (err_count_r != {ERR_CNT_WIDTH{1'b1}})) begin
                err_count_r <= err_count_r + ERR_CNT_WIDTH'(1'b1);
            end
            if (err_clr) begin
                overrun_r <= 1'b0;
            end else if (overrun_event_s) begin
                overrun_r <= 1'b1;
            end
        end
    end

    assign req_ready    = ready_s;
    assign sched_wen    = wen_r;
    assign sched_packet = packet_r;
    assign sched_clr    = clr_r;
    assign sched_set    = set_r;
    assign tick_done    = done_r;
    assign err_count    = err_count_r;
    assign tick_overrun = overrun_r;

endmodule

// File: tb/tb_scheduler_input_arbiter.sv
// Bench for scheduler_input_arbiter: constant vector table, directed tick/error/reset
// sequences and random traffic, all checked against a cycle-timeline reference model.
module tb_scheduler_input_arbiter;

    localparam int NP   = 2;
    localparam int PW   = 12;
    localparam int EW   = 8;
    localparam int CMAX = 8192;

    logic             clk;
    logic             rst;
    logic             tick;
    logic [NP-1:0]    req_valid;
    logic [NP*PW-1:0] req_packet;
    logic [NP-1:0]    req_ready;
    logic             sched_wen;
    logic [PW-1:0]    sched_packet;
    logic             sched_clr;
    logic             sched_set;
    logic             sched_error;
    logic             err_clr;
    logic             tick_done;
    logic [EW-1:0]    err_count;
    logic             tick_overrun;

    scheduler_input_arbiter #(
        .NUM_PORTS     (NP),
        .NUM_AXONS     (256),
        .NUM_TICKS     (16),
        .ERR_CNT_WIDTH (EW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .req_valid    (req_valid),
        .req_packet   (req_packet),
        .req_ready    (req_ready),
        .sched_wen    (sched_wen),
        .sched_packet (sched_packet),
        .sched_clr    (sched_clr),
        .sched_set    (sched_set),
        .sched_error  (sched_error),
        .err_clr      (err_clr),
        .tick_done    (tick_done),
        .err_count    (err_count),
        .tick_overrun (tick_overrun)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    int vec_cnt  = 0;
    int miss_cnt = 0;

    // Reference model: absolute cycle timeline of expected clr/set pulses
    int            cyc;
    int            busy_until;
    int            last_gnt;
    int            errc;
    bit            m_valid;
    bit            m_ovr;
    bit            m_wen;
    logic [PW-1:0] m_pkt;
    bit            exp_clr_a [CMAX];
    bit            exp_set_a [CMAX];
    int            done_seen;
    int            set_seen;

    logic [NP-1:0] s_ready;
    logic          s_wen;
    logic [PW-1:0] s_pkt;
    logic          s_clr;
    logic          s_set;
    logic          s_done;

    typedef struct {
        bit            r;
        bit            t;
        logic [NP-1:0] v;
        bit            se;
        bit            ec;
        logic [NP-1:0] e_ready;
        bit            e_wen;
        logic [PW-1:0] e_pkt;
        bit            e_clr;
        bit            e_set;
    } vec_t;

    vec_t tbl [13];

    task automatic check(input string name, input int act, input int exp);
        vec_cnt++;
        if (act != exp) begin
            miss_cnt++;
            $display("FAIL %s cycle %0d: got 0x%0h required 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic int model_grant(input logic [NP-1:0] v);
        for (int k = 1; k <= NP; k++) begin
            int p;
            p = (last_gnt + k) % NP;
            if (v[p]) return p;
        end
        return -1;
    endfunction

    task automatic step(input bit r, input bit t, input logic [NP-1:0] v,
                        input logic [PW-1:0] p0, input logic [PW-1:0] p1,
                        input bit se, input bit ec);
        int            g;
        logic [NP-1:0] exp_r;
        bit            ovr_ev;
        rst = r; tick = t; req_valid = v; req_packet = {p1, p0};
        sched_error = se; err_clr = ec;
        g = model_grant(v);
        exp_r = '0;
        if (r && !t && (cyc > busy_until) && (g >= 0)) exp_r[g] = 1'b1;
        @(negedge clk);
        s_ready = req_ready; s_wen = sched_wen; s_pkt = sched_packet;
        s_clr = sched_clr; s_set = sched_set; s_done = tick_done;
        if (tick_done) done_seen++;
        if (sched_set) set_seen++;
        if (m_valid) begin
            check("req_ready",    int'(req_ready),    int'(exp_r));
            check("sched_wen",    int'(sched_wen),    int'(m_wen));
            check("sched_packet", int'(sched_packet), int'(m_pkt));
            check("sched_clr",    int'(sched_clr),    int'(exp_clr_a[cyc]));
            check("sched_set",    int'(sched_set),    int'(exp_set_a[cyc]));
            check("tick_done",    int'(tick_done),    int'(exp_set_a[cyc]));
            check("err_count",    int'(err_count),    errc);
            check("tick_overrun", int'(tick_overrun), int'(m_ovr));
        end
        if (!r) begin
            last_gnt = NP - 1; busy_until = cyc; errc = 0; m_ovr = 1'b0;
            m_wen = 1'b0; m_pkt = '0; m_valid = 1'b1;
            for (int k = 1; k <= 4; k++) begin
                exp_clr_a[cyc + k] = 1'b0;
                exp_set_a[cyc + k] = 1'b0;
            end
        end else begin
            if (ec) errc = 0;
            else if (m_wen && se && errc < 255) errc++;
            ovr_ev = 1'b0;
            if (t) begin
                if (cyc > busy_until) begin
                    exp_clr_a[cyc + 1] = 1'b1; exp_set_a[cyc + 2] = 1'b1;
                    busy_until = cyc + 2;
                end else if (busy_until - cyc <= 1) begin
                    exp_clr_a[busy_until + 1] = 1'b1; exp_set_a[busy_until + 2] = 1'b1;
                    busy_until = busy_until + 2;
                end else begin
                    ovr_ev = 1'b1;
                end
            end
            m_ovr = ec ? 1'b0 : (m_ovr | ovr_ev);
            if (exp_r != '0) begin
                m_wen = 1'b1; m_pkt = (g == 0) ? p0 : p1; last_gnt = g;
            end else begin
                m_wen = 1'b0;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int d0;
        cyc = 0; busy_until = 0; last_gnt = NP - 1; errc = 0; m_valid = 1'b0;
        m_ovr = 1'b0; m_wen = 1'b0; m_pkt = '0; done_seen = 0; set_seen = 0;
        rst = 1'b0; tick = 1'b0; req_valid = '0; req_packet = '0;
        sched_error = 1'b0; err_clr = 1'b0;

        //            r     t     v      se    ec    ready  wen   pkt      clr   set
        tbl[0]  = '{1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 2'b00, 1'b0, 12'h000, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 12'h000, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 12'h000, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 2'b01, 1'b0, 12'h000, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 2'b10, 1'b1, 12'h123, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 2'b01, 1'b1, 12'h456, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 2'b10, 1'b1, 12'h123, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 1'b1, 12'h456, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 12'h456, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 12'h456, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 2'b01, 1'b0, 12'h456, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 12'h123, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 12'h123, 1'b0, 1'b0};

        // First edge establishes reset; outputs before it are undefined
        step(1'b0, 1'b0, 2'b11, 12'h123, 12'h456, 1'b0, 1'b0);

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].r, tbl[i].t, tbl[i].v, 12'h123, 12'h456, tbl[i].se, tbl[i].ec);
            check($sformatf("table_row%0d", i),
                  int'({s_ready, s_wen, s_pkt, s_clr, s_set, s_done}),
                  int'({tbl[i].e_ready, tbl[i].e_wen, tbl[i].e_pkt,
                        tbl[i].e_clr, tbl[i].e_set, tbl[i].e_set}));
        end

        // Ticks in ACCEPT, CLR and SET: two sequences back-to-back, third tick overruns
        d0 = done_seen;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 2'b00, 12'h0, 12'h0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 2'b00, 12'h0, 12'h0, 1'b0, 1'b0);
        check("tick_done_count", done_seen - d0, 2);
        check("overrun_set", int'(tick_overrun), 1);
        step(1'b1, 1'b0, 2'b00, 12'h0, 12'h0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 2'b00, 12'h0, 12'h0, 1'b0, 1'b0);
        check("overrun_clr", int'(tick_overrun), 0);

        // Collision counter saturation, then clear wins over a simultaneous increment
        for (int i = 0; i < 302; i++) step(1'b1, 1'b0, 2'b01, 12'hABC, 12'h0, 1'b1, 1'b0);
        check("err_saturate", int'(err_count), 255);
        step(1'b1, 1'b0, 2'b01, 12'hABC, 12'h0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 2'b00, 12'h0, 12'h0, 1'b0, 1'b0);
        check("err_cleared", int'(err_count), 0);

        // Reset during CLR aborts the sequence
        step(1'b1, 1'b1, 2'b00, 12'h0, 12'h0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 2'b00, 12'h0, 12'h0, 1'b0, 1'b0);
        d0 = set_seen;
        step(1'b1, 1'b0, 2'b10, 12'h0, 12'h777, 1'b0, 1'b0);
        check("accept_after_reset", int'(s_ready), 2);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'b00, 12'h0, 12'h0, 1'b0, 1'b0);
        check("no_set_after_reset", set_seen - d0, 0);

        // Random traffic against the model
        for (int i = 0; i < 2500; i++) begin
            step(($urandom_range(0, 199) != 0), ($urandom_range(0, 5) == 0),
                 NP'($urandom), PW'($urandom), PW'($urandom),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 49) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
